// File: rtl/imem_arbiter.sv
// Instruction-RAM port arbiter: shares one single-port RAM between the fetch
// stage (reads) and a host loader (writes), with a starvation cap on host bursts.
module imem_arbiter #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned HOST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [31:0]       pc,
   output logic              stall,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_inst,
   input  logic              host_req,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic              ram_ena,
   output logic              ram_wena,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int unsigned CNT_W = (HOST_MAX < 1) ? 1 : $clog2(HOST_MAX + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                fetch_valid_q;
   logic                grant;
   logic                starved;
   logic [ADDR_W-1:0]   pc_word;
   logic                unused_pc;

   assign pc_word   = pc[ADDR_W+1:2];
   assign unused_pc = ^{pc[31:ADDR_W+2], pc[1:0]};

   // State, starvation counter, write latches and read-valid pipeline
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         fetch_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         fetch_valid_q <= grant;
      end
   end

   // Arbitration, next state and RAM/handshake outputs
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      grant     = 1'b0;
      starved   = 1'b0;
      host_ack  = 1'b0;
      ram_ena   = 1'b0;
      ram_wena  = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;

      unique case (state_q)
         IDLE: begin
            starved = fetch_req && (cnt_q == CNT_W'(HOST_MAX));
            if (host_req && !starved) begin
               state_d = WR;
               addr_d  = host_addr;
               wdata_d = host_wdata;
               if (fetch_req && (cnt_q < CNT_W'(HOST_MAX))) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (fetch_req) begin
               grant    = 1'b1;
               cnt_d    = '0;
               ram_ena  = 1'b1;
               ram_addr = pc_word;
            end
         end
         WR: begin
            ram_ena   = 1'b1;
            ram_wena  = 1'b1;
            ram_addr  = addr_q;
            ram_wdata = wdata_q;
            state_d   = ACK;
         end
         ACK: begin
            host_ack = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Everything the block drives is held low while reset is asserted
      if (!rst_n) begin
         grant     = 1'b0;
         host_ack  = 1'b0;
         ram_ena   = 1'b0;
         ram_wena  = 1'b0;
         ram_addr  = '0;
         ram_wdata = '0;
      end
   end

   assign stall       = rst_n && fetch_req && !grant;
   assign fetch_valid = rst_n && fetch_valid_q;
   assign fetch_inst  = fetch_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a timeline-based model.
module tb_imem_arbiter;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 3;
   localparam int unsigned HOST_MAX = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              fetch_req;
   logic [31:0]       pc;
   logic              stall;
   logic              fetch_valid;
   logic [DATA_W-1:0] fetch_inst;
   logic              host_req;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_ack;
   logic              ram_ena;
   logic              ram_wena;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   imem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HOST_MAX(HOST_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc(pc), .stall(stall),
      .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .host_req(host_req),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
      .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: a write accepted in cycle t writes at t+1 and acks at t+2;
   // the port is free for arbitration in every other cycle.
   int          cyc     = 0;
   int          wr_at   = -10;
   int          ack_at  = -10;
   int          waits   = 0;
   bit          prev_rd = 1'b0;
   logic [2:0]  lat_a   = '0;
   logic [31:0] lat_d   = '0;
   bit          m_accept;

   logic        s_stall, s_fv, s_ack, s_ena, s_wena;
   logic [31:0] s_fi, s_wdata;
   logic [2:0]  s_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic fr, input logic [31:0] p,
                       input logic hr, input logic [2:0] ha, input logic [31:0] hw,
                       input logic [31:0] rd);
      bit          rd_now, wr_now, ack_now, starve;
      logic [2:0]  e_addr;
      logic [31:0] e_wdata;
      @(negedge clk);
      rst_n = r; fetch_req = fr; pc = p; host_req = hr;
      host_addr = ha; host_wdata = hw; ram_rdata = rd;
      #1;
      s_stall = stall; s_fv = fetch_valid; s_fi = fetch_inst; s_ack = host_ack;
      s_ena = ram_ena; s_wena = ram_wena; s_addr = ram_addr; s_wdata = ram_wdata;

      rd_now = 0; wr_now = 0; ack_now = 0; m_accept = 0;
      if (r) begin
         if (cyc == wr_at) wr_now = 1;
         else if (cyc == ack_at) ack_now = 1;
         else begin
            starve = fr && (waits == HOST_MAX);
            if (hr && !starve) begin
               m_accept = 1; wr_at = cyc + 1; ack_at = cyc + 2;
               lat_a = ha; lat_d = hw;
               if (fr && waits < HOST_MAX) waits++;
            end else if (fr) begin
               rd_now = 1; waits = 0;
            end
         end
      end
      e_addr  = rd_now ? p[4:2] : (wr_now ? lat_a : 3'd0);
      e_wdata = wr_now ? lat_d : 32'd0;
      chk("m_stall",  32'(s_stall), 32'(r && fr && !rd_now));
      chk("m_ack",    32'(s_ack),   32'(ack_now));
      chk("m_ena",    32'(s_ena),   32'(rd_now || wr_now));
      chk("m_wena",   32'(s_wena),  32'(wr_now));
      chk("m_addr",   32'(s_addr),  32'(e_addr));
      chk("m_wdata",  s_wdata,      e_wdata);
      chk("m_fvalid", 32'(s_fv),    32'(r && prev_rd));
      chk("m_finst",  s_fi,         (r && prev_rd) ? rd : 32'd0);

      if (!r) begin
         prev_rd = 0; waits = 0; wr_at = -10; ack_at = -10; lat_a = '0; lat_d = '0;
      end else begin
         prev_rd = rd_now;
      end
      cyc++;
   endtask

   bit          w_arr [0:16];
   bit          st_arr[0:16];
   bit          en_arr[0:16];
   int          cnt_a, cnt_b, first_ack;
   bit          h_pend;
   logic [2:0]  h_a;
   logic [31:0] h_d;
   logic        r_r, r_f;

   initial begin
      rst_n = 0; fetch_req = 0; pc = 0; host_req = 0; host_addr = 0;
      host_wdata = 0; ram_rdata = 0;

      // Reset: outputs held at zero even with requests present
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 32'h0C, 1, 3'd2, 32'h11, 32'h55);
      chk("rst_stall", 32'(s_stall), 0);
      chk("rst_ena",   32'(s_ena),   0);
      chk("rst_ack",   32'(s_ack),   0);
      chk("rst_finst", s_fi,         0);

      // Fetch only
      step(1, 1, 32'h0C, 0, 0, 0, 0);
      chk("fo_ena",  32'(s_ena),  1);
      chk("fo_addr", 32'(s_addr), 3);
      chk("fo_wena", 32'(s_wena), 0);
      step(1, 0, 0, 0, 0, 0, 32'hDEADBEEF);
      chk("fo_fvalid", 32'(s_fv), 1);
      chk("fo_finst",  s_fi,      32'hDEADBEEF);
      chk("fo_stall",  32'(s_stall), 0);

      // Host write alone
      step(1, 0, 0, 1, 3'd5, 32'h12345678, 0);
      chk("hw_noacc", 32'(s_ena), 0);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("hw_wena",  32'(s_wena), 1);
      chk("hw_addr",  32'(s_addr), 5);
      chk("hw_wdata", s_wdata, 32'h12345678);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("hw_ack", 32'(s_ack), 1);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("hw_ack_once", 32'(s_ack), 0);

      // Contention: four writes, one starved fetch, then writes resume
      for (int i = 0; i < 17; i++) begin
         step(1, 1, 32'h1C, 1, 3'd2, 32'hA5A5A5A5, 32'h0);
         w_arr[i] = s_wena; st_arr[i] = s_stall; en_arr[i] = s_ena;
      end
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 12; i++) begin
         cnt_a += int'(w_arr[i]);
         cnt_b += int'(st_arr[i]);
      end
      chk("ct_writes", 32'(cnt_a), 4);
      chk("ct_stalls", 32'(cnt_b), 12);
      chk("ct_rd_ena", 32'(en_arr[12] && !w_arr[12]), 1);
      chk("ct_rd_stall", 32'(st_arr[12]), 0);
      chk("ct_resume", 32'(en_arr[13] == 0 && st_arr[13] == 1 && w_arr[14] == 1), 1);
      repeat (3) step(1, 0, 0, 0, 0, 0, 0);

      // Host request held through ACK: back-to-back writes, acks 3 apart
      cnt_a = 0; first_ack = -1; cnt_b = -1;
      for (int i = 0; i < 7; i++) begin
         step(1, 0, 0, 1, 3'd1, 32'h0BADF00D, 0);
         if (s_ack) begin
            cnt_a++;
            if (first_ack < 0) first_ack = i; else cnt_b = i - first_ack;
         end
      end
      chk("bb_acks",  32'(cnt_a), 2);
      chk("bb_first", 32'(first_ack), 2);
      chk("bb_gap",   32'(cnt_b), 3);
      repeat (3) step(1, 0, 0, 0, 0, 0, 0);

      // Reset in the WR cycle aborts the write and its ack
      step(1, 0, 0, 1, 3'd6, 32'h77777777, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("ra_ena",   32'(s_ena),   0);
      chk("ra_stall", 32'(s_stall), 0);
      step(1, 1, 32'h14, 0, 0, 0, 0);
      chk("ra_ack",   32'(s_ack),   0);
      chk("ra_grant", 32'(s_ena && !s_wena), 1);
      chk("ra_addr",  32'(s_addr),  5);
      step(1, 0, 0, 0, 0, 0, 32'hCAFEF00D);
      chk("ra_ack2",  32'(s_ack), 0);
      chk("ra_finst", s_fi, 32'hCAFEF00D);

      // Randomized traffic; host holds each request until it is accepted
      h_pend = 0; h_a = 0; h_d = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!h_pend && ($urandom_range(0, 2) == 0)) begin
            h_pend = 1; h_a = 3'($urandom); h_d = $urandom;
         end
         r_r = ($urandom_range(0, 49) != 0);
         r_f = ($urandom_range(0, 3) != 0);
         step(r_r, r_f, $urandom, h_pend, h_a, h_d, $urandom);
         if (m_accept) h_pend = 0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, instruction/RAM word width.
REQ-002 Parameter ADDR_W, default 3, instruction RAM word-address width (8 words).
REQ-003 Parameter HOST_MAX, default 4, max consecutive host writes granted while fetch waits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 fetch_req  input  1  fetch stage requests an instruction read this cycle.
REQ-007 pc  input  32  current PC; word address is pc[ADDR_W+1:2].
REQ-008 stall  output  1  fetch_req high but read not granted this cycle.
REQ-009 fetch_valid  output  1  fetch_inst holds the word read in the previous cycle.
REQ-010 fetch_inst  output  DATA_W  ram_rdata when fetch_valid, else 0.
REQ-011 host_req  input  1  host requests one instruction-RAM write.
REQ-012 host_addr  input  ADDR_W  host write word address.
REQ-013 host_wdata  input  DATA_W  host write data.
REQ-014 host_ack  output  1  one-cycle pulse: host write completed.
REQ-015 ram_ena  output  1  RAM enable.
REQ-016 ram_wena  output  1  RAM write enable (1 = write).
REQ-017 ram_addr  output  ADDR_W  RAM word address.
REQ-018 ram_wdata  output  DATA_W  RAM write data.
REQ-019 ram_rdata  input  DATA_W  synchronous-read RAM output, valid one cycle after a read.

Function
REQ-020 FSM states SHALL be IDLE, WR, ACK; one transition per clock.
REQ-021 IDLE: starved = fetch_req && cnt==HOST_MAX; if host_req && !starved -> WR, latch host_addr/host_wdata, no RAM access this cycle.
REQ-022 IDLE otherwise: if fetch_req, grant read (ram_ena=1, ram_wena=0, ram_addr=pc[ADDR_W+1:2]), stay IDLE; if no request, RAM idle.
REQ-023 WR: drive ram_ena=1, ram_wena=1, ram_addr/ram_wdata = latched values; -> ACK unconditionally.
REQ-024 ACK: host_ack=1, RAM idle, no fetch grant; host_req ignored; -> IDLE.
REQ-025 Host handshake: host holds req/addr/wdata until sampled in IDLE; one write per ack; host deasserts req in ACK cycle or a new write starts next IDLE.
REQ-026 Starvation counter cnt (width fits HOST_MAX): +1 on each IDLE->WR with fetch_req=1, saturating at HOST_MAX; cleared to 0 on every granted fetch read; unchanged otherwise.
REQ-027 stall = fetch_req && no fetch grant this cycle (combinational); stall=1 in WR and ACK whenever fetch_req=1.
REQ-028 fetch_valid SHALL register the fetch-grant bit: high exactly one cycle after each granted read.
REQ-029 When ram_ena=0, ram_wena, ram_addr, ram_wdata SHALL be 0.
REQ-030 Simultaneous host_req and fetch_req in IDLE: host wins unless starved; starved: fetch wins, counter clears, host retries next IDLE.
REQ-031 Max host write latency from sampled request to host_ack: 3 cycles (IDLE, WR, ACK), plus at most 1 cycle if starved.

Reset
REQ-032 rst_n=0 at a clock edge: state=IDLE, cnt=0, latches=0, fetch_valid=0; while rst_n=0, all outputs 0 (stall, host_ack, ram_*, fetch_inst).
REQ-033 Reset during WR or ACK SHALL abort the write/ack; no host_ack issued for the aborted transaction.

Verification
REQ-034 Fetch only: fetch_req=1, pc=0x0C, ram_rdata=0xDEADBEEF -> ram_ena=1, ram_addr=3 same cycle; next cycle fetch_valid=1, fetch_inst=0xDEADBEEF, stall=0.
REQ-035 Host write alone: host_req=1, addr=5, wdata=0x12345678 -> next cycle ram_wena=1, ram_addr=5, ram_wdata=0x12345678; following cycle host_ack=1 for one cycle.
REQ-036 Contention, HOST_MAX=4: fetch_req=1, host_req=1 continuously -> 4 writes (stall=1 throughout), then one fetch read granted in IDLE with cnt cleared, then writes resume.
REQ-037 Host_req held through ACK -> second write starts in following IDLE, exactly one host_ack per write, acks 3 cycles apart.
REQ-038 rst_n=0 asserted in WR cycle -> no host_ack, all outputs 0 next cycle; after release, fetch_req=1 grants read immediately.
